// File: rtl/out_register.sv
// Receive-side bus capture register with a small FIFO and valid/ready output.
//
// Ports:
//   Clock, Reset            : rising-edge clock, async active-high reset
//   B0..B3                  : shared 4-bit bus, B0 is the LSB
//   EnableOut               : capture strobe, samples the bus on the clock edge
//   OutReady                : downstream consumer ready
//   ClearOvf                : synchronous clear of the sticky Overflow flag
//   DataOut, OutValid       : registered head word and its valid flag
//   Full, Empty, Count      : FIFO occupancy, derived from the registered count
//   Overflow                : sticky flag, set when a capture is dropped
// Optional feature macro OUT_REGISTER_PARITY_EN adds:
//   BP (input)              : even-parity bit for the bus
//   ParityErr (output)      : stored parity result of the head word
module out_register #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          B0,
    input  logic          B1,
    input  logic          B2,
    input  logic          B3,
    input  logic          EnableOut,
    input  logic          OutReady,
    input  logic          ClearOvf,
`ifdef OUT_REGISTER_PARITY_EN
    input  logic          BP,
    output logic          ParityErr,
`endif
    output logic [3:0]    DataOut,
    output logic          OutValid,
    output logic          Full,
    output logic          Empty,
    output logic [CW-1:0] Count,
    output logic          Overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef OUT_REGISTER_PARITY_EN
    localparam int EW = 5;
`else
    localparam int EW = 4;
`endif
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef logic [EW-1:0] entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        head_q, head_d;
    logic          ovf_q, ovf_d;

    logic          push;
    logic          pop;
    logic          ovf_event;
    logic [3:0]    bus_word;
    entry_t        wr_entry;

    assign bus_word = {B3, B2, B1, B0};

`ifdef OUT_REGISTER_PARITY_EN
    // Stored bit is 1 when the word plus BP has odd parity.
    assign wr_entry = {(^bus_word) ^ BP, bus_word};
`else
    assign wr_entry = bus_word;
`endif

    always_comb begin
        pop       = (count_q != '0) && OutReady;
        // A full FIFO still accepts a word when the head leaves this edge.
        push      = EnableOut && ((count_q != DEPTH_C) || pop);
        ovf_event = EnableOut && (count_q == DEPTH_C) && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        ovf_d    = ovf_q;

        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        // The head register reloads only when the head entry changes:
        // after a pop, or when the first word lands in an empty FIFO.
        // The new head may be the word being written on this same edge.
        if ((count_d != '0) && (pop || (count_q == '0))) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wr_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

`ifdef OUT_REGISTER_PARITY_EN
        // Data holds when empty but the parity flag must read 0.
        if (count_d == '0) begin
            head_d[EW-1] = 1'b0;
        end
`endif

        // Set has priority over clear.
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (ClearOvf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    assign DataOut  = head_q[3:0];
    assign Count    = count_q;
    assign Empty    = (count_q == '0);
    assign Full     = (count_q == DEPTH_C);
    assign OutValid = !Empty;
    assign Overflow = ovf_q;

`ifdef OUT_REGISTER_PARITY_EN
    assign ParityErr = head_q[EW-1];
`endif

endmodule

// File: tb/tb_out_register.sv
// Testbench for out_register: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_out_register;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          Clock;
    logic          Reset;
    logic [3:0]    bus_v;
    logic          bp_v;
    logic          EnableOut;
    logic          OutReady;
    logic          ClearOvf;
    logic [3:0]    DataOut;
    logic          OutValid;
    logic          Full;
    logic          Empty;
    logic [CW-1:0] Count;
    logic          Overflow;
    logic          perr_obs;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of {parity_flag, word}, held head word, sticky flag.
    logic [4:0] mq[$];
    logic [3:0] m_data;
    logic       m_ovf;

`ifdef OUT_REGISTER_PARITY_EN
    logic ParityErr;
    out_register #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clock(Clock), .Reset(Reset),
        .B0(bus_v[0]), .B1(bus_v[1]), .B2(bus_v[2]), .B3(bus_v[3]),
        .EnableOut(EnableOut), .OutReady(OutReady), .ClearOvf(ClearOvf),
        .BP(bp_v), .ParityErr(ParityErr),
        .DataOut(DataOut), .OutValid(OutValid), .Full(Full), .Empty(Empty),
        .Count(Count), .Overflow(Overflow)
    );
    assign perr_obs = ParityErr;
`else
    out_register #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clock(Clock), .Reset(Reset),
        .B0(bus_v[0]), .B1(bus_v[1]), .B2(bus_v[2]), .B3(bus_v[3]),
        .EnableOut(EnableOut), .OutReady(OutReady), .ClearOvf(ClearOvf),
        .DataOut(DataOut), .OutValid(OutValid), .Full(Full), .Empty(Empty),
        .Count(Count), .Overflow(Overflow)
    );
    assign perr_obs = 1'b0;
`endif

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [11:0] obs_vec();
        return {DataOut, OutValid, Full, Empty, Count, Overflow, perr_obs};
    endfunction

    function automatic logic [11:0] exp_vec();
        int n;
        logic pe;
        n  = mq.size();
        pe = (n > 0) ? mq[0][4] : 1'b0;
        return {m_data, n > 0, n == DEPTH, n == 0, CW'(n), m_ovf, pe};
    endfunction

    function automatic logic par_flag(input logic [3:0] b, input logic bp);
`ifdef OUT_REGISTER_PARITY_EN
        return (^b) ^ bp;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_data = 4'h0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [3:0] b,
                              input logic bp, input logic rdy,
                              input logic clr);
        int   n;
        logic do_pop;
        logic do_push;
        logic ovf_ev;
        n       = mq.size();
        do_pop  = (n > 0) && rdy;
        do_push = en && ((n < DEPTH) || do_pop);
        ovf_ev  = en && (n == DEPTH) && !do_pop;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({par_flag(b, bp), b});
        if (mq.size() > 0) m_data = mq[0][3:0];
        if (ovf_ev) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // Drive one cycle of inputs, advance past the edge, sample at +1.
    task automatic cycle(input logic en, input logic [3:0] b, input logic bp,
                         input logic rdy, input logic clr);
        EnableOut = en;
        bus_v     = b;
        bp_v      = bp;
        OutReady  = rdy;
        ClearOvf  = clr;
        model_step(en, b, bp, rdy, clr);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        EnableOut = 1'b0;
        OutReady  = 1'b0;
        ClearOvf  = 1'b0;
        Reset     = 1'b1;
        model_reset();
        #2;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (obs_vec() !== exp_vec())
            $display("FAIL reset_state got=%h want=%h", obs_vec(), exp_vec());
        else n_pass++;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 9), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (Count !== 3'd3)
            $display("FAIL pre_reset_count got=%0d want=3", Count);
        else n_pass++;
        Reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({Count, Empty, OutValid, DataOut} !== {3'd0, 1'b1, 1'b0, 4'h0})
            $display("FAIL async_reset got=%h want=%h",
                     {Count, Empty, OutValid, DataOut},
                     {3'd0, 1'b1, 1'b0, 4'h0});
        else n_pass++;
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({OutValid, DataOut, Count} !== {1'b1, 4'hA, 3'd1})
            $display("FAIL latency_head got=%h want=%h",
                     {OutValid, DataOut, Count}, {1'b1, 4'hA, 3'd1});
        else n_pass++;
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({Empty, OutValid, DataOut} !== {1'b1, 1'b0, 4'hA})
            $display("FAIL latency_pop got=%h want=%h",
                     {Empty, OutValid, DataOut}, {1'b1, 1'b0, 4'hA});
        else n_pass++;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({Full, Count, Overflow} !== {1'b1, 3'd4, 1'b0})
            $display("FAIL fill_full got=%h want=%h",
                     {Full, Count, Overflow}, {1'b1, 3'd4, 1'b0});
        else n_pass++;
        cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({Overflow, Count} !== {1'b1, 3'd4})
            $display("FAIL overflow_set got=%h want=%h",
                     {Overflow, Count}, {1'b1, 3'd4});
        else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if ({OutValid, DataOut} !== {1'b1, 4'(i)})
                $display("FAIL drain_%0d got=%h want=%h", i,
                         {OutValid, DataOut}, {1'b1, 4'(i)});
            else n_pass++;
            cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        end
        n_checks++;
        if ({Empty, DataOut, Overflow} !== {1'b1, 4'h4, 1'b1})
            $display("FAIL drain_end got=%h want=%h",
                     {Empty, DataOut, Overflow}, {1'b1, 4'h4, 1'b1});
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [3:0] want [4];
        want = '{4'h2, 4'h3, 4'h4, 4'h7};
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({Count, Full, Overflow} !== {3'd4, 1'b1, 1'b0})
            $display("FAIL full_pushpop got=%h want=%h",
                     {Count, Full, Overflow}, {3'd4, 1'b1, 1'b0});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({OutValid, DataOut} !== {1'b1, want[i]})
                $display("FAIL fpp_drain_%0d got=%h want=%h", i,
                         {OutValid, DataOut}, {1'b1, want[i]});
            else n_pass++;
            cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] got[$];
        int         budget;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (OutValid) got.push_back(DataOut);
            cycle(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL wrap_step_%0d got=%h want=%h", i,
                         obs_vec(), exp_vec());
            else n_pass++;
        end
        budget = 8;
        while (OutValid && budget > 0) begin
            got.push_back(DataOut);
            cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
            budget--;
        end
        n_checks++;
        if (got.size() != 12 || !Empty)
            $display("FAIL wrap_count got=%0d want=12", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 12; i++) begin
            n_checks++;
            if (got[i] !== 4'(i))
                $display("FAIL wrap_order_%0d got=%h want=%h", i,
                         got[i], 4'(i));
            else n_pass++;
        end
    endtask

    task automatic test_clear_ovf();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({Overflow, Count} !== {1'b0, 3'd4})
            $display("FAIL clear_ovf got=%h want=%h",
                     {Overflow, Count}, {1'b0, 3'd4});
        else n_pass++;
        cycle(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (Overflow !== 1'b1)
            $display("FAIL set_wins_from0 got=%b want=1", Overflow);
        else n_pass++;
        cycle(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (Overflow !== 1'b1)
            $display("FAIL set_wins_from1 got=%b want=1", Overflow);
        else n_pass++;
    endtask

`ifdef OUT_REGISTER_PARITY_EN
    task automatic test_parity();
        do_reset();
        cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({OutValid, DataOut, ParityErr} !== {1'b1, 4'h3, 1'b0})
            $display("FAIL parity_first got=%h want=%h",
                     {OutValid, DataOut, ParityErr}, {1'b1, 4'h3, 1'b0});
        else n_pass++;
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({OutValid, DataOut, ParityErr} !== {1'b1, 4'h3, 1'b1})
            $display("FAIL parity_second got=%h want=%h",
                     {OutValid, DataOut, ParityErr}, {1'b1, 4'h3, 1'b1});
        else n_pass++;
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({Empty, ParityErr} !== {1'b1, 1'b0})
            $display("FAIL parity_empty got=%h want=%h",
                     {Empty, ParityErr}, {1'b1, 1'b0});
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic       en;
        logic       rdy;
        logic       clr;
        logic       bp;
        logic [3:0] b;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 9) == 0);
            bp  = 1'($urandom);
            b   = 4'($urandom);
            cycle(en, b, bp, rdy, clr);
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random_%0d got=%h want=%h", i,
                         obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        Reset     = 1'b1;
        bus_v     = 4'h0;
        bp_v      = 1'b0;
        EnableOut = 1'b0;
        OutReady  = 1'b0;
        ClearOvf  = 1'b0;
        model_reset();
        test_reset();
        test_latency();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_clear_ovf();
`ifdef OUT_REGISTER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
